dialog_text_overlay: RTL and testbench
======================================

// Module: dialog_text_overlay
// PURPOSE
//  Parametrised multi-line, multi-page dialog box overlay for the game VGA pipeline. Renders
//  NUM_LINES x CHARS_PER_LINE 8x16 glyphs at (X0,Y0) with a per-frame typewriter reveal.
//  Key-driven page advance; a pulse is raised at end of dialog. Sits between game content and
//  the next VGA stage; uses an external page text ROM and font_rom, each 1-cycle synchronous.
// PARAMETERS
//  NUM_PAGES      4       pages per dialog
//  NUM_LINES      5       text lines per page
//  CHARS_PER_LINE 32      glyphs per line
//  X0             64      box left pixel column
//  Y0             352     box top pixel row
//  REVEAL_FRAMES  2       frames per revealed glyph, >=1
//  FG_COLOR       12'hFFF glyph colour
//  BG_COLOR       12'h000 box background colour
// PORTS
//  clk           in  1   pixel clock
//  rst           in  1   synchronous reset, active-low
//  start         in  1   1-cycle pulse: open dialog at page 0
//  key_advance   in  1   advance key level, synchronous to clk
//  in_hcount     in  11  VGA timing in (likewise in_vcount 11, in_hsync/in_vsync/in_hblnk/in_vblnk 1)
//  in_rgb        in  12  background pixel
//  out_hcount    out 11  timing out (likewise out_vcount, out_hsync/out_vsync/out_hblnk/out_vblnk)
//  out_rgb       out 12  composed pixel
//  char_xy       out PW+LW+CW  {page,line,col} to text ROM; PW/LW/CW = $clog2 of the counts
//  char_code     in  7   text ROM data, valid 1 cycle after char_xy
//  font_addr     out 11  {char_code, glyph_row[3:0]} to font_rom
//  font_pixels   in  8   font_rom data, valid 1 cycle after font_addr; bit 7 = leftmost
//  page          out PW  current page index
//  dialog_active out 1   box visible
//  dialog_end    out 1   1-cycle pulse when last page is dismissed
// BEHAVIOUR
//  Reset (rst==0 at edge): all out_* = 0, page=0, revealed=0, dialog_active=0, dialog_end=0,
//  state=IDLE, key edge register=0.
//  Pipeline: out_* = in_* delayed exactly 4 clk (char_xy reg -> text ROM -> font ROM -> out reg).
//  Box: hcount in [X0, X0+8*CHARS_PER_LINE), vcount in [Y0, Y0+16*NUM_LINES), both unblanked;
//   col=(h-X0)>>3, line=(v-Y0)>>4, glyph_row=(v-Y0)[3:0], bit=(h-X0)[2:0], delayed to align.
//  Pixel: inside box && active -> FG_COLOR if font_pixels[7-bit] && line*CHARS_PER_LINE+col < revealed,
//   else BG_COLOR; otherwise in_rgb unchanged. Inactive: pure 4-cycle passthrough.
//  Frame tick: rising edge of in_vblnk; revealed += 1 every REVEAL_FRAMES ticks in TYPING,
//   saturating at TOTAL = NUM_LINES*CHARS_PER_LINE.
//  Key edge: key_advance 0->1, registered; holding the key gives exactly one edge.
//  FSM:
//   IDLE     : start -> TYPING, page=0, revealed=0, active=1, frame counter cleared.
//   TYPING   : revealed==TOTAL -> WAIT_KEY; key edge -> revealed=TOTAL, WAIT_KEY (skip).
//   WAIT_KEY : key edge and page<NUM_PAGES-1 -> page+1, revealed=0, TYPING;
//              key edge and page==NUM_PAGES-1 -> IDLE, active=0, dialog_end=1 for 1 cycle, page held.
//  start in TYPING/WAIT_KEY restarts at page 0 (start beats a simultaneous key edge).
//  Frame tick and key edge in same cycle: key edge wins (no extra reveal increment).
//  Reset mid-dialog: immediately IDLE with reset values; no dialog_end pulse.
//  char_xy is driven every cycle regardless of state; ROM reads have no side effects.
// TESTING
//  1 Reset, start, REVEAL_FRAMES=1: after 3 vblnk edges revealed=3; glyph pixels in col 3 are BG_COLOR.
//  2 Pixel at (X0,Y0), char_code 'A' whose row-0 byte is 8'h80: out_rgb=FG_COLOR 4 clk later; (X0-1,Y0) = in_rgb.
//  3 Key edge mid-TYPING: revealed=TOTAL next cycle, state WAIT_KEY, page unchanged.
//  4 Key held 100 cycles in WAIT_KEY page 0: page=1 once, revealed=0; release+press -> page 2.
//  5 Key edge in WAIT_KEY on page 3: dialog_end high exactly 1 cycle, active=0, out_rgb==in_rgb delayed.
//  6 Assert rst mid-TYPING on page 2: next cycle page=0, active=0, out_*=0, no dialog_end.

Source files
------------

// File: rtl/dialog_text_overlay.sv
// Dialog box overlay: renders a typewriter-revealed, multi-page text box over the VGA stream
// using an external page text ROM and font ROM, each with one cycle of read latency.
module dialog_text_overlay #(
    parameter int unsigned NUM_PAGES      = 4,
    parameter int unsigned NUM_LINES      = 5,
    parameter int unsigned CHARS_PER_LINE = 32,
    parameter int unsigned X0             = 64,
    parameter int unsigned Y0             = 352,
    parameter int unsigned REVEAL_FRAMES  = 2,
    parameter logic [11:0] FG_COLOR       = 12'hFFF,
    parameter logic [11:0] BG_COLOR       = 12'h000,
    localparam int unsigned PW = $clog2(NUM_PAGES),
    localparam int unsigned LW = $clog2(NUM_LINES),
    localparam int unsigned CW = $clog2(CHARS_PER_LINE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   key_advance,
    input  logic [10:0]            in_hcount,
    input  logic [10:0]            in_vcount,
    input  logic                   in_hsync,
    input  logic                   in_vsync,
    input  logic                   in_hblnk,
    input  logic                   in_vblnk,
    input  logic [11:0]            in_rgb,
    output logic [10:0]            out_hcount,
    output logic [10:0]            out_vcount,
    output logic                   out_hsync,
    output logic                   out_vsync,
    output logic                   out_hblnk,
    output logic                   out_vblnk,
    output logic [11:0]            out_rgb,
    output logic [PW+LW+CW-1:0]    char_xy,
    input  logic [6:0]             char_code,
    output logic [10:0]            font_addr,
    input  logic [7:0]             font_pixels,
    output logic [PW-1:0]          page,
    output logic                   dialog_active,
    output logic                   dialog_end
);

    localparam int unsigned TOTAL = NUM_LINES * CHARS_PER_LINE;
    localparam int unsigned RW    = $clog2(TOTAL + 1);
    localparam int unsigned FW    = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam int unsigned BOX_W = 8 * CHARS_PER_LINE;
    localparam int unsigned BOX_H = 16 * NUM_LINES;
    localparam int unsigned TW    = 38;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TYPING   = 2'd1,
        WAIT_KEY = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   page_d;
    logic [RW-1:0]   revealed_q, revealed_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            active_d;
    logic            end_d;
    logic            key_q;
    logic            vblnk_q;
    logic            key_edge;
    logic            frame_tick;

    logic [10:0]     dx;
    logic [10:0]     dy;
    logic            in_box_c;
    logic [CW-1:0]   col_c;
    logic [LW-1:0]   line_c;
    logic [RW-1:0]   idx_c;
    logic [TW-1:0]   tim_c;

    logic [TW-1:0]   tim_s [3];
    logic            box_s [3];
    logic [2:0]      bit_s [3];
    logic [RW-1:0]   idx_s [3];
    logic [3:0]      row_s1;
    logic [3:0]      row_s2;
    logic            lit;
    logic [11:0]     rgb_c;

    assign key_edge   = key_advance & ~key_q;
    assign frame_tick = in_vblnk & ~vblnk_q;

    // Box geometry decode on the incoming pixel
    assign dx       = in_hcount - 11'(X0);
    assign dy       = in_vcount - 11'(Y0);
    assign in_box_c = !in_hblnk && !in_vblnk
                   && (in_hcount >= 11'(X0)) && (in_hcount < 11'(X0 + BOX_W))
                   && (in_vcount >= 11'(Y0)) && (in_vcount < 11'(Y0 + BOX_H));
    assign col_c    = CW'(dx >> 3);
    assign line_c   = LW'(dy >> 4);
    assign idx_c    = RW'(line_c) * RW'(CHARS_PER_LINE) + RW'(col_c);
    assign tim_c    = {in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk, in_rgb};

    // Glyph row travels with the text ROM read so the font lookup lines up with char_code
    assign font_addr = {char_code, row_s2};

    assign lit   = font_pixels[3'd7 - bit_s[2]] && (idx_s[2] < revealed_q);
    assign rgb_c = (box_s[2] && dialog_active) ? (lit ? FG_COLOR : BG_COLOR) : tim_s[2][11:0];

    // Dialog control: start overrides everything, key edge overrides a frame tick
    always_comb begin
        state_d    = state_q;
        page_d     = page;
        revealed_d = revealed_q;
        frame_d    = frame_q;
        end_d      = 1'b0;
        if (start) begin
            state_d    = TYPING;
            page_d     = '0;
            revealed_d = '0;
            frame_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                TYPING: begin
                    if (key_edge) begin
                        revealed_d = RW'(TOTAL);
                        frame_d    = '0;
                        state_d    = WAIT_KEY;
                    end else if (revealed_q == RW'(TOTAL)) begin
                        state_d = WAIT_KEY;
                    end else if (frame_tick) begin
                        if (frame_q == FW'(REVEAL_FRAMES - 1)) begin
                            frame_d    = '0;
                            revealed_d = revealed_q + RW'(1);
                        end else begin
                            frame_d = frame_q + FW'(1);
                        end
                    end
                end
                WAIT_KEY: begin
                    if (key_edge) begin
                        if (page == PW'(NUM_PAGES - 1)) begin
                            state_d = IDLE;
                            end_d   = 1'b1;
                        end else begin
                            page_d     = page + PW'(1);
                            revealed_d = '0;
                            frame_d    = '0;
                            state_d    = TYPING;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            page          <= '0;
            revealed_q    <= '0;
            frame_q       <= '0;
            dialog_active <= 1'b0;
            dialog_end    <= 1'b0;
            key_q         <= 1'b0;
            vblnk_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            page          <= page_d;
            revealed_q    <= revealed_d;
            frame_q       <= frame_d;
            dialog_active <= active_d;
            dialog_end    <= end_d;
            key_q         <= key_advance;
            vblnk_q       <= in_vblnk;
        end
    end

    // Four-stage video pipeline: ROM address, text ROM, font ROM, composed output
    always_ff @(posedge clk) begin
        if (!rst) begin
            char_xy    <= '0;
            row_s1     <= '0;
            row_s2     <= '0;
            for (int i = 0; i < 3; i++) begin
                tim_s[i] <= '0;
                box_s[i] <= 1'b0;
                bit_s[i] <= '0;
                idx_s[i] <= '0;
            end
            out_hcount <= '0;
            out_vcount <= '0;
            out_hsync  <= 1'b0;
            out_vsync  <= 1'b0;
            out_hblnk  <= 1'b0;
            out_vblnk  <= 1'b0;
            out_rgb    <= '0;
        end else begin
            char_xy  <= {page, line_c, col_c};
            row_s1   <= dy[3:0];
            row_s2   <= row_s1;
            tim_s[0] <= tim_c;
            box_s[0] <= in_box_c;
            bit_s[0] <= dx[2:0];
            idx_s[0] <= idx_c;
            for (int i = 1; i < 3; i++) begin
                tim_s[i] <= tim_s[i-1];
                box_s[i] <= box_s[i-1];
                bit_s[i] <= bit_s[i-1];
                idx_s[i] <= idx_s[i-1];
            end
            {out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk} <= tim_s[2][TW-1:12];
            out_rgb <= rgb_c;
        end
    end

endmodule

// File: tb/tb_dialog_text_overlay.sv
// Randomized scoreboard bench for dialog_text_overlay: behavioural dialog model plus
// ROM models; a negedge monitor compares every output pixel against queued expectations.
module tb_dialog_text_overlay;

    localparam int unsigned NP    = 4;
    localparam int unsigned NL    = 5;
    localparam int unsigned CPL   = 32;
    localparam int unsigned X0    = 64;
    localparam int unsigned Y0    = 352;
    localparam int unsigned RF    = 2;
    localparam int unsigned TOTAL = NL * CPL;
    localparam logic [11:0] FG    = 12'hFFF;
    localparam logic [11:0] BG    = 12'h000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        key_advance;
    logic [10:0] in_hcount, in_vcount;
    logic        in_hsync, in_vsync, in_hblnk, in_vblnk;
    logic [11:0] in_rgb;
    logic [10:0] out_hcount, out_vcount;
    logic        out_hsync, out_vsync, out_hblnk, out_vblnk;
    logic [11:0] out_rgb;
    logic [9:0]  char_xy;
    logic [6:0]  char_code;
    logic [10:0] font_addr;
    logic [7:0]  font_pixels;
    logic [1:0]  page;
    logic        dialog_active;
    logic        dialog_end;

    dialog_text_overlay #(
        .NUM_PAGES(NP), .NUM_LINES(NL), .CHARS_PER_LINE(CPL), .X0(X0), .Y0(Y0),
        .REVEAL_FRAMES(RF), .FG_COLOR(FG), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .key_advance(key_advance),
        .in_hcount(in_hcount), .in_vcount(in_vcount), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .in_hblnk(in_hblnk), .in_vblnk(in_vblnk), .in_rgb(in_rgb),
        .out_hcount(out_hcount), .out_vcount(out_vcount), .out_hsync(out_hsync),
        .out_vsync(out_vsync), .out_hblnk(out_hblnk), .out_vblnk(out_vblnk), .out_rgb(out_rgb),
        .char_xy(char_xy), .char_code(char_code), .font_addr(font_addr),
        .font_pixels(font_pixels), .page(page), .dialog_active(dialog_active),
        .dialog_end(dialog_end)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] text_fn(input int pg, input int ln, input int cl);
        if (pg == 0 && ln == 0 && cl == 0) return 7'h41;
        return 7'((pg * 31 + ln * 17 + cl * 3 + 5) % 128);
    endfunction

    function automatic logic [7:0] font_fn(input logic [6:0] code, input int row);
        if (code == 7'h41 && row == 0) return 8'h80;
        return 8'((int'(code) * 7 + row * 13) ^ 165);
    endfunction

    // Synchronous ROMs in the environment
    always @(posedge clk) begin
        char_code   <= text_fn(int'(char_xy[9:8]), int'(char_xy[7:5]), int'(char_xy[4:0]));
        font_pixels <= font_fn(font_addr[10:4], int'(font_addr[3:0]));
    end

    typedef struct {
        int          due;
        int          h;
        int          v;
        logic [37:0] want;
    } exp_t;

    exp_t q[$];
    int   cyc        = 0;
    int   checks     = 0;
    int   errors     = 0;
    int   end_cycles = 0;
    logic cur_key    = 1'b0;

    int   m_page, m_rev, m_frames, m_end;
    bit   m_active, m_wait, m_prev_key, m_prev_vb;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (dialog_end === 1'b1) end_cycles <= end_cycles + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            chk($sformatf("pix h=%0d v=%0d", q[0].h, q[0].v),
                64'({out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb}),
                64'(q[0].want));
            void'(q.pop_front());
        end
    end

    function automatic void model_reset();
        m_page = 0; m_rev = 0; m_frames = 0;
        m_active = 0; m_wait = 0; m_prev_key = 0; m_prev_vb = 0;
    endfunction

    // Dialog behaviour as a plain event model
    function automatic void model_step(input logic s, input logic k, input logic vb);
        bit kedge, tick;
        kedge = k && !m_prev_key;
        tick  = vb && !m_prev_vb;
        m_prev_key = k;
        m_prev_vb  = vb;
        if (s) begin
            m_active = 1; m_wait = 0; m_page = 0; m_rev = 0; m_frames = 0;
        end else if (m_active && kedge) begin
            if (!m_wait) begin
                m_rev = TOTAL; m_wait = 1; m_frames = 0;
            end else if (m_page < int'(NP) - 1) begin
                m_page++; m_rev = 0; m_frames = 0; m_wait = 0;
            end else begin
                m_active = 0; m_wait = 0; m_end++;
            end
        end else if (m_active && !m_wait && tick) begin
            m_frames++;
            if (m_frames == int'(RF)) begin
                m_frames = 0;
                m_rev++;
                if (m_rev == int'(TOTAL)) m_wait = 1;
            end
        end
    endfunction

    function automatic logic [11:0] exp_rgb(input int h, input int v, input logic hb,
                                            input logic vb, input logic [11:0] rgb);
        int dx, dy, col, ln;
        logic [7:0] bits;
        if (!m_active || hb || vb) return rgb;
        dx = h - int'(X0);
        dy = v - int'(Y0);
        if (dx < 0 || dx >= int'(8 * CPL) || dy < 0 || dy >= int'(16 * NL)) return rgb;
        col  = dx / 8;
        ln   = dy / 16;
        bits = font_fn(text_fn(m_page, ln, col), dy % 16);
        if (bits[7 - dx % 8] && (ln * int'(CPL) + col < m_rev)) return FG;
        return BG;
    endfunction

    task automatic drive(input int h, input int v, input logic hb, input logic vb, input logic s);
        logic [11:0] rgb;
        logic hs, vs;
        exp_t e;
        @(posedge clk); #1;
        rgb = 12'($urandom);
        hs  = 1'($urandom);
        vs  = 1'($urandom);
        in_hcount = 11'(h); in_vcount = 11'(v); in_hsync = hs; in_vsync = vs;
        in_hblnk = hb; in_vblnk = vb; in_rgb = rgb; start = s; key_advance = cur_key;
        model_step(s, cur_key, vb);
        e.due  = cyc + 4;
        e.h    = h;
        e.v    = v;
        e.want = {11'(h), 11'(v), hs, vs, hb, vb, exp_rgb(h, v, hb, vb, rgb)};
        q.push_back(e);
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++)
            drive(int'($urandom_range(0, 1023)), int'($urandom_range(0, 700)), 1'b1, 1'b0, 1'b0);
    endtask

    // Pixels near or inside the box, then a blanked gap so no event lands in their pipeline
    task automatic burst(input int n, input bit focus);
        int h, v;
        for (int i = 0; i < n; i++) begin
            if (focus) begin
                h = int'(X0) + int'($urandom_range(0, 47));
                v = int'(Y0) + int'($urandom_range(0, 15));
            end else begin
                h = int'($urandom_range(X0 + 8 * CPL + 15, X0 - 16));
                v = int'($urandom_range(Y0 + 16 * NL + 7, Y0 - 8));
            end
            drive(h, v, 1'($urandom_range(0, 15) == 0), 1'b0, 1'b0);
        end
        blank(4);
    endtask

    task automatic px(input int h, input int v);
        drive(h, v, 1'b0, 1'b0, 1'b0);
        blank(4);
    endtask

    task automatic vpulse();
        drive(int'($urandom_range(0, 1023)), int'($urandom_range(0, 700)), 1'b1, 1'b1, 1'b0);
        drive(int'($urandom_range(0, 1023)), int'($urandom_range(0, 700)), 1'b1, 1'b1, 1'b0);
        blank(1);
    endtask

    task automatic hold_key(input int n);
        cur_key = 1'b1;
        blank(n);
        cur_key = 1'b0;
        blank(3);
    endtask

    task automatic start_pulse();
        drive(0, 0, 1'b1, 1'b0, 1'b1);
        blank(3);
    endtask

    task automatic status(input string tag);
        chk({tag, " page"}, 64'(page), 64'(m_page));
        chk({tag, " active"}, 64'(dialog_active), 64'(m_active));
        chk({tag, " dialog_end count"}, 64'(end_cycles), 64'(m_end));
    endtask

    task automatic do_reset();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        chk("scoreboard drained", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0; cur_key = 1'b0; key_advance = 1'b0; in_vblnk = 1'b0;
        in_hcount = 11'($urandom_range(1, 1023)); in_vcount = 11'($urandom_range(1, 700));
        in_rgb = 12'($urandom_range(1, 4095)); in_hsync = 1'b1; in_vsync = 1'b1; in_hblnk = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk("reset out_*", 64'({out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb}), 64'd0);
        chk("reset page", 64'(page), 64'd0);
        chk("reset active", 64'(dialog_active), 64'd0);
        chk("reset dialog_end", 64'(dialog_end), 64'd0);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; key_advance = 1'b0;
        in_hcount = '0; in_vcount = '0; in_hsync = 1'b0; in_vsync = 1'b0;
        in_hblnk = 1'b0; in_vblnk = 1'b0; in_rgb = '0;
        m_end = 0;
        model_reset();
        do_reset();
        blank(4);
        burst(40, 0);
        status("idle");

        start_pulse();
        status("started");
        burst(40, 0);
        repeat (6) vpulse();
        burst(60, 1);
        px(int'(X0), int'(Y0));
        px(int'(X0) - 1, int'(Y0));
        px(int'(X0) + 24, int'(Y0));
        burst(30, 0);

        hold_key(1);
        status("skip p0");
        burst(60, 0);
        hold_key(100);
        status("held key");
        burst(30, 0);
        hold_key(1);
        hold_key(1);
        status("page 2");

        repeat (3) vpulse();
        cur_key = 1'b1;
        drive(0, 0, 1'b1, 1'b1, 1'b0);
        cur_key = 1'b0;
        drive(0, 0, 1'b1, 1'b0, 1'b0);
        blank(3);
        status("key+tick");
        burst(30, 1);

        hold_key(1);
        status("page 3");
        repeat (330) vpulse();
        burst(40, 0);
        hold_key(1);
        status("dismissed");
        burst(40, 0);

        start_pulse();
        repeat (2) vpulse();
        cur_key = 1'b1;
        drive(0, 0, 1'b1, 1'b0, 1'b1);
        cur_key = 1'b0;
        blank(3);
        status("start+key");
        burst(20, 1);
        repeat (4) hold_key(1);
        repeat (4) vpulse();
        status("typing p2");
        burst(20, 1);
        do_reset();
        blank(3);
        status("after reset");
        burst(30, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        chk("final drain", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
